// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller (MEM stage).
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   cpu_req_i           MEM-stage access valid
//   cpu_write_i         1 = store, 0 = load
//   cpu_addr_i          word-aligned byte address
//   cpu_wdata_i         store data
//   cpu_rdata_o         load data, valid when cpu_req_i & !cpu_stall_o
//   cpu_stall_o         pipeline stall (MemStall), combinational
//   mem_req_o           line request to data memory, held until mem_ack_i
//   mem_write_o         1 = line writeback, 0 = line refill
//   mem_addr_o          line-aligned memory address
//   mem_wdata_o         victim line for writeback
//   mem_rdata_i         refill line, valid with mem_ack_i
//   mem_ack_i           one-cycle completion pulse
module dcache_ctrl #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_BYTES = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpu_req_i,
    input  logic                      cpu_write_i,
    input  logic [31:0]               cpu_addr_i,
    input  logic [31:0]               cpu_wdata_i,
    output logic [31:0]               cpu_rdata_o,
    output logic                      cpu_stall_o,
    output logic                      mem_req_o,
    output logic                      mem_write_o,
    output logic [31:0]               mem_addr_o,
    output logic [LINE_BYTES*8-1:0]   mem_wdata_o,
    input  logic [LINE_BYTES*8-1:0]   mem_rdata_i,
    input  logic                      mem_ack_i
);

    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned WSEL_W = OFF_W - 2;
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned BOFF_W = $clog2(LINE_W);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic [TAG_W-1:0]  req_tag;
    logic [BOFF_W-1:0] word_off;
    logic [LINE_W-1:0] sel_line;
    logic              hit;
    logic              wr_hit;
    logic              refill_done;
    logic              unused_addr_lsb;

    assign req_idx         = cpu_addr_i[OFF_W +: IDX_W];
    assign req_wsel        = cpu_addr_i[2 +: WSEL_W];
    assign req_tag         = cpu_addr_i[31 -: TAG_W];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];
    assign word_off        = {req_wsel, 5'b0};
    assign sel_line        = data_q[req_idx];

    assign hit         = cpu_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign wr_hit      = (state_q == StIdle) & hit & cpu_write_i;
    assign refill_done = (state_q == StRefill) & mem_ack_i;

    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        cpu_rdata_o = sel_line[word_off +: 32];
                    end else begin
                        cpu_stall_o = 1'b1;
                        // A dirty victim must reach memory before its slot is refilled.
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_d = StWriteback;
                        end else begin
                            state_d = StRefill;
                        end
                    end
                end
            end
            StWriteback: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                // Tag array still holds the victim tag until the refill lands.
                mem_addr_o  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                mem_wdata_o = sel_line;
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (refill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end else if (wr_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_rdata_i;
        end else if (wr_hit) begin
            data_q[req_idx][word_off +: 32] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(
        .NUM_LINES (16),
        .LINE_BYTES(32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_write_i(cpu_write_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_req_o  (mem_req_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    // Called one step after a negedge with the DUT already in the handshake state.
    // Checks the request for lat cycles, acks in the last one, returns in the cycle after.
    task automatic serve(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                         input logic chk_wd, input logic [255:0] exp_wd,
                         input logic [255:0] rdata, input int lat);
        for (int i = 1; i <= lat; i++) begin
            chk({tag, "_req"}, 256'(mem_req_o), 256'(1));
            chk({tag, "_wr"}, 256'(mem_write_o), 256'(exp_wr));
            chk({tag, "_addr"}, 256'(mem_addr_o), 256'(exp_addr));
            chk({tag, "_stall"}, 256'(cpu_stall_o), 256'(1));
            if (chk_wd) chk({tag, "_wdata"}, mem_wdata_o, exp_wd);
            if (i == lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end
            @(negedge clk_i);
            #1;
        end
        mem_ack_i = 1'b0;
    endtask

    logic [255:0] exp_wb;

    initial begin
        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_req", 256'(mem_req_o), 256'(0));
        chk("rst_wr", 256'(mem_write_o), 256'(0));
        chk("rst_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_wdata", mem_wdata_o, 256'(0));
        chk("rst_rdata", 256'(cpu_rdata_o), 256'(0));
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        rst_i = 1'b0;

        // Clean load miss, ack latency 3 -> 4 stall cycles.
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h40;
        #1;
        chk("m1_stall0", 256'(cpu_stall_o), 256'(1));
        chk("m1_noreq0", 256'(mem_req_o), 256'(0));
        @(negedge clk_i);
        #1;
        serve("m1_rf", 1'b0, 32'h40, 1'b0, '0, mk_line(32'h100), 3);
        chk("m1_stall_end", 256'(cpu_stall_o), 256'(0));
        chk("m1_rdata", 256'(cpu_rdata_o), 256'(32'h100));
        chk("m1_req_end", 256'(mem_req_o), 256'(0));

        // Load hit, same cycle.
        cpu_addr_i = 32'h4C;
        #1;
        chk("h_stall", 256'(cpu_stall_o), 256'(0));
        chk("h_rdata", 256'(cpu_rdata_o), 256'(32'h103));
        chk("h_req", 256'(mem_req_o), 256'(0));

        // Store hit then read back.
        @(negedge clk_i);
        cpu_write_i = 1'b1;
        cpu_addr_i  = 32'h44;
        cpu_wdata_i = 32'hDEADBEEF;
        #1;
        chk("sh_stall", 256'(cpu_stall_o), 256'(0));
        chk("sh_req", 256'(mem_req_o), 256'(0));
        @(negedge clk_i);
        cpu_write_i = 1'b0;
        #1;
        chk("sh_rdata", 256'(cpu_rdata_o), 256'(32'hDEADBEEF));
        chk("sh_stall2", 256'(cpu_stall_o), 256'(0));

        // Conflict miss on dirty line: writeback 0x40 then refill 0x240.
        exp_wb = mk_line(32'h100);
        exp_wb[63:32] = 32'hDEADBEEF;
        @(negedge clk_i);
        cpu_addr_i = 32'h240;
        #1;
        chk("wb_stall0", 256'(cpu_stall_o), 256'(1));
        chk("wb_noreq0", 256'(mem_req_o), 256'(0));
        @(negedge clk_i);
        #1;
        serve("wb", 1'b1, 32'h40, 1'b1, exp_wb, '0, 2);
        serve("wb_rf", 1'b0, 32'h240, 1'b0, '0, mk_line(32'h300), 3);
        chk("wb_stall_end", 256'(cpu_stall_o), 256'(0));
        chk("wb_rdata", 256'(cpu_rdata_o), 256'(32'h300));

        // Store miss to clean (invalid) line: refill only, merge on the hit cycle.
        @(negedge clk_i);
        cpu_write_i = 1'b1;
        cpu_addr_i  = 32'h80;
        cpu_wdata_i = 32'hCAFEF00D;
        #1;
        chk("sm_stall0", 256'(cpu_stall_o), 256'(1));
        @(negedge clk_i);
        #1;
        serve("sm_rf", 1'b0, 32'h80, 1'b0, '0, mk_line(32'h500), 2);
        chk("sm_stall_end", 256'(cpu_stall_o), 256'(0));
        chk("sm_req_end", 256'(mem_req_o), 256'(0));
        @(negedge clk_i);
        cpu_write_i = 1'b0;
        #1;
        chk("sm_rdata", 256'(cpu_rdata_o), 256'(32'hCAFEF00D));

        // Evicting that line proves it was marked dirty.
        exp_wb = mk_line(32'h500);
        exp_wb[31:0] = 32'hCAFEF00D;
        @(negedge clk_i);
        cpu_addr_i = 32'h280;
        #1;
        chk("ev_stall0", 256'(cpu_stall_o), 256'(1));
        @(negedge clk_i);
        #1;
        serve("ev_wb", 1'b1, 32'h80, 1'b1, exp_wb, '0, 1);
        serve("ev_rf", 1'b0, 32'h280, 1'b0, '0, mk_line(32'h600), 1);
        chk("ev_rdata", 256'(cpu_rdata_o), 256'(32'h600));

        // Reset in the middle of a refill.
        @(negedge clk_i);
        cpu_addr_i = 32'h300;
        @(negedge clk_i);
        #1;
        chk("rr_req_pre", 256'(mem_req_o), 256'(1));
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        #1;
        chk("rr_req", 256'(mem_req_o), 256'(0));
        chk("rr_stall", 256'(cpu_stall_o), 256'(0));
        chk("rr_addr", 256'(mem_addr_o), 256'(0));
        chk("rr_rdata", 256'(cpu_rdata_o), 256'(0));
        @(negedge clk_i);
        rst_i     = 1'b0;
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chk("rr_stray_req", 256'(mem_req_o), 256'(0));
        chk("rr_stray_stall", 256'(cpu_stall_o), 256'(0));
        // Line 0x280 was valid before reset; now it must miss with no writeback.
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h280;
        #1;
        chk("rr_inval_stall", 256'(cpu_stall_o), 256'(1));
        @(negedge clk_i);
        #1;
        serve("rr_rf", 1'b0, 32'h280, 1'b0, '0, mk_line(32'h700), 1);
        chk("rr_rdata2", 256'(cpu_rdata_o), 256'(32'h700));
        cpu_req_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
